// File: rtl/ss_pkg.sv
// Shared definitions for the serial frame deserializer.
// - state_t        : receive FSM state encoding (2-bit)
// - IDLE_LVL       : line level of an idle serial wire and of a valid stop bit
// - DEFAULT_DATA_W : default number of data bits per frame
package ss_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic IDLE_LVL       = 1'b1;
  localparam int   DEFAULT_DATA_W = 8;

endpackage

// File: rtl/ss_bit_counter.sv
// Data-bit counter for the frame deserializer.
// Ports:
//   clk, rst_n : system clock, synchronous active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : count one received data bit
//   term       : high while the NEXT counted bit is the last data bit,
//                i.e. the count reaches DATA_W on the enabled edge
module ss_bit_counter #(
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign term = (count == CW'(DATA_W - 1));

endmodule

// File: rtl/ss_frame_deserializer.sv
// Framed serial word receiver: start bit 0, DATA_W data bits, optional even
// parity bit, stop bit 1. Reassembled words are offered on a valid/ready port.
// Ports:
//   clk, rst_n        : system clock, synchronous active-low reset
//   serial_in, bit_en : serial stream, sampled only when bit_en=1
//   lsb_first         : data bit order, latched on the start bit
//   data_out, data_valid, data_ready : word handshake output
//   busy              : receiver is inside a frame
//   frame_err, parity_err, overrun   : sticky status, cleared by err_clr
//   state             : debug view of the receive FSM
//
// Handshake: data_out is transferred on every edge where data_valid and
// data_ready are both 1. data_valid stays high, with data_out stable, until
// that transfer; a word delivered on the same edge replaces it and keeps
// data_valid high.
module ss_frame_deserializer
  import ss_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              serial_in,
  input  logic              bit_en,
  input  logic              lsb_first,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun,
  input  logic              err_clr,
  output state_t            state
);

  state_t            state_q, state_nxt;
  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              lsb_q;
  logic              par_bad_q;
  logic              ferr_q, perr_q, ovr_q;

  logic cnt_clr, cnt_en, cnt_term, stop_smp;
  logic frame_evt, par_evt, good, ovr_evt, load, consume;

  ss_bit_counter #(.DATA_W(DATA_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .term  (cnt_term)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    stop_smp  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bit_en && (serial_in != IDLE_LVL)) begin
          state_nxt = DATA;
          cnt_clr   = 1'b1;
        end
      end
      DATA: begin
        if (bit_en) begin
          cnt_en = 1'b1;
          if (cnt_term) begin
            if (PARITY_EN) state_nxt = PARITY;
            else           state_nxt = STOP;
          end
        end
      end
      PARITY: begin
        if (bit_en) state_nxt = STOP;
      end
      STOP: begin
        // A 0 here is a framing error, never a new start bit: we always
        // return to IDLE and only look for a start on the next strobe.
        if (bit_en) begin
          state_nxt = IDLE;
          stop_smp  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stop-bit outcome, in priority order: framing, parity, then delivery.
  assign frame_evt = stop_smp && (serial_in != IDLE_LVL);
  assign par_evt   = stop_smp && (serial_in == IDLE_LVL) && par_bad_q;
  assign good      = stop_smp && (serial_in == IDLE_LVL) && !par_bad_q;
  assign consume   = valid_q && data_ready;
  assign ovr_evt   = good && valid_q && !data_ready;
  assign load      = good && !ovr_evt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      lsb_q     <= 1'b0;
      par_bad_q <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      if (cnt_clr) begin
        lsb_q     <= lsb_first;
        par_bad_q <= 1'b0;
      end
      // LSB-first enters at the top and drifts down; MSB-first enters at bit 0.
      if (cnt_en) begin
        if (lsb_q) shreg_q <= {serial_in, shreg_q[DATA_W-1:1]};
        else       shreg_q <= {shreg_q[DATA_W-2:0], serial_in};
      end
      if ((state_q == PARITY) && bit_en) begin
        par_bad_q <= (^shreg_q) ^ serial_in;
      end
      if (load) begin
        data_q  <= shreg_q;
        valid_q <= 1'b1;
      end else if (consume) begin
        valid_q <= 1'b0;
      end
      // Clear first, then a same-cycle event sets the flag again.
      ferr_q <= (ferr_q && !err_clr) || frame_evt;
      perr_q <= (perr_q && !err_clr) || par_evt;
      ovr_q  <= (ovr_q  && !err_clr) || ovr_evt;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign busy       = (state_q != IDLE);
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign overrun    = ovr_q;
  assign state      = state_q;

endmodule
